fetch_stage_dslot: RTL



---
 rtl/fetch_stage_dslot_pkg.sv | 15 +
 rtl/fetch_stage_dslot_pc_npc_pair.sv | 49 ++++
 rtl/fetch_stage_dslot.sv | 79 +++++++
 3 files changed

// File: rtl/fetch_stage_dslot_pkg.sv
// Shared fetch-stage constants and the decode-to-fetch control bundle.
// The hazard unit reuses the same bundle.
package fetch_stage_dslot_pkg;

   localparam int unsigned FETCH_INC_DEF = 4;
   localparam logic [31:0] FETCH_NOP_DEF = 32'h0100_0000;   // sethi 0,%g0
   localparam int unsigned FETCH_TGT_W   = 32;               // widest supported ADDR_W

   typedef struct packed {
      logic                   br_taken;
      logic                   squash_slot;
      logic [FETCH_TGT_W-1:0] br_target;
   } fetch_ctl_t;

endpackage

// File: rtl/fetch_stage_dslot_pc_npc_pair.sv
// PC/nPC register pair with +INC adder and delayed-branch redirect.
// A redirect loads the target into pc, so the slot already at pc is still fetched.
module pc_npc_pair
   import fetch_stage_dslot_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int unsigned       INC      = FETCH_INC_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              le_i,
   input  fetch_ctl_t        ctl_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] npc_o
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] npc_q, npc_d;
   logic [ADDR_W-1:0] base;
   logic              unused_ctl;

   // Upper target bits and the squash flag do not affect the PC pair.
   assign unused_ctl = ^{ctl_i.squash_slot, ctl_i.br_target};

   always_comb begin
      pc_d  = pc_q;
      npc_d = npc_q;
      base  = ctl_i.br_taken ? ctl_i.br_target[ADDR_W-1:0] : npc_q;
      if (le_i) begin
         pc_d  = base;
         npc_d = base + ADDR_W'(INC);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q  <= RESET_PC;
         npc_q <= RESET_PC + ADDR_W'(INC);
      end else begin
         pc_q  <= pc_d;
         npc_q <= npc_d;
      end
   end

   assign pc_o  = pc_q;
   assign npc_o = npc_q;

endmodule

// File: rtl/fetch_stage_dslot.sv
// Instruction-fetch front end: PC/nPC pair plus IF/ID register with
// delay-slot annulment.
module fetch_stage_dslot
   import fetch_stage_dslot_pkg::*;
#(
   parameter int unsigned        ADDR_W   = 8,
   parameter int unsigned        INSTR_W  = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int unsigned        INC      = FETCH_INC_DEF,
   parameter logic [INSTR_W-1:0] NOP_WORD = INSTR_W'(FETCH_NOP_DEF)
) (
   input  logic               Clk,
   input  logic               R,
   input  logic               LE,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               br_taken,
   input  logic [ADDR_W-1:0]  br_target,
   input  logic               squash_slot,
   output logic [ADDR_W-1:0]  pc,
   output logic [ADDR_W-1:0]  npc,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic               if_id_valid
);

   fetch_ctl_t         ctl;
   logic [ADDR_W-1:0]  pc_w;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  ifpc_q, ifpc_d;
   logic               valid_q, valid_d;

   assign ctl = '{br_taken:    br_taken,
                  squash_slot: squash_slot,
                  br_target:   FETCH_TGT_W'(br_target)};

   pc_npc_pair #(
      .ADDR_W   (ADDR_W),
      .RESET_PC (RESET_PC),
      .INC      (INC)
   ) u_pc_npc (
      .clk_i (Clk),
      .rst_i (R),
      .le_i  (LE),
      .ctl_i (ctl),
      .pc_o  (pc_w),
      .npc_o (npc)
   );

   always_comb begin
      instr_d = instr_q;
      ifpc_d  = ifpc_q;
      valid_d = valid_q;
      if (LE) begin
         instr_d = squash_slot ? NOP_WORD : imem_data;
         ifpc_d  = pc_w;
         valid_d = ~squash_slot;
      end
   end

   always_ff @(posedge Clk) begin
      if (R) begin
         instr_q <= NOP_WORD;
         ifpc_q  <= RESET_PC;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         ifpc_q  <= ifpc_d;
         valid_q <= valid_d;
      end
   end

   assign pc          = pc_w;
   assign imem_addr   = pc_w;
   assign if_id_instr = instr_q;
   assign if_id_pc    = ifpc_q;
   assign if_id_valid = valid_q;

endmodule
